iob_rom_rr_arbiter: RTL and testbench

IOB_ROM_RR_ARBITER -- requirements
Module: iob_rom_rr_arbiter

---
 rtl/iob_rom_rr_arbiter_if.sv | 69 ++++++
 rtl/iob_rom_rr_arbiter.sv | 169 ++++++++++++++++
 tb/tb_iob_rom_rr_arbiter.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iob_rom_rr_arbiter_if.sv
// ----------------------------------------------------------------------------
// iob_rom_rr_arbiter_if
//
// Purpose : bundles the two requester read ports and the single-port ROM
//           port served by iob_rom_rr_arbiter.
//
// Handshake (applies to both requester ports):
//   A request transfers on a rising clock edge where rN_valid_i and rN_ready_o
//   are both 1. Once it raises rN_valid_i, the requester keeps rN_valid_i and
//   rN_addr_i stable until that edge. rN_ready_o is a pure function of the
//   valid inputs and the arbiter's priority pointer; it never waits on
//   anything downstream. Read data is returned as a one-cycle rN_rvalid_o
//   pulse two cycles after the transfer, with no back-pressure.
//
// Signals (direction as seen by the arbiter, i.e. the slave modport):
//   r1_valid_i/r2_valid_i   in   read request
//   r1_addr_i/r2_addr_i     in   read address (ADDR_W)
//   r1_ready_o/r2_ready_o   out  request accepted this cycle
//   r1_rdata_o/r2_rdata_o   out  read data (DATA_W), held between reads
//   r1_rvalid_o/r2_rvalid_o out  read data valid, one-cycle pulse
//   rom_en_o                out  ROM read enable
//   rom_addr_o              out  ROM read address (ADDR_W)
//   rom_data_i              in   ROM read data, valid the cycle after rom_en_o
// ----------------------------------------------------------------------------
interface iob_rom_rr_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);

  // Requester 1
  logic              r1_valid_i;
  logic [ADDR_W-1:0] r1_addr_i;
  logic              r1_ready_o;
  logic [DATA_W-1:0] r1_rdata_o;
  logic              r1_rvalid_o;

  // Requester 2
  logic              r2_valid_i;
  logic [ADDR_W-1:0] r2_addr_i;
  logic              r2_ready_o;
  logic [DATA_W-1:0] r2_rdata_o;
  logic              r2_rvalid_o;

  // Single-port ROM
  logic              rom_en_o;
  logic [ADDR_W-1:0] rom_addr_o;
  logic [DATA_W-1:0] rom_data_i;

  // Arbiter side
  modport slave (
    input  r1_valid_i, r1_addr_i,
    output r1_ready_o, r1_rdata_o, r1_rvalid_o,
    input  r2_valid_i, r2_addr_i,
    output r2_ready_o, r2_rdata_o, r2_rvalid_o,
    output rom_en_o, rom_addr_o,
    input  rom_data_i
  );

  // Requester / ROM side
  modport master (
    output r1_valid_i, r1_addr_i,
    input  r1_ready_o, r1_rdata_o, r1_rvalid_o,
    output r2_valid_i, r2_addr_i,
    input  r2_ready_o, r2_rdata_o, r2_rvalid_o,
    input  rom_en_o, rom_addr_o,
    output rom_data_i
  );

endinterface

// File: rtl/iob_rom_rr_arbiter.sv
// ----------------------------------------------------------------------------
// iob_rom_rr_arbiter
//
// Purpose : shares one synchronous single-port ROM between two read
//           requesters with round-robin priority. One request is accepted per
//           cycle; its data comes back to the requesting port two cycles
//           later as a one-cycle rvalid pulse.
//
// Ports:
//   clk_i       in   single clock, rising edge
//   arst_n_i    in   asynchronous reset, active low
//   bus         --   iob_rom_rr_arbiter_if.slave: both requester ports and the
//                    ROM port (see the interface file for the handshake)
//   prio_dbg_o  out  current priority pointer (0 = port 1, 1 = port 2)
//
// Timing of one read accepted in cycle N:
//   cycle N   : rN_ready_o = 1, rom_en_o = 1, rom_addr_o = address
//   edge N    : ROM latches the address; stage 1 records {valid, port id}
//   cycle N+1 : ROM drives the data on rom_data_i
//   edge N+1  : stage 2 loads rom_data_i into the recorded port's rdata
//   cycle N+2 : that port's rvalid is 1
// Reads pipeline back-to-back, so responses leave in acceptance order.
// ----------------------------------------------------------------------------
module iob_rom_rr_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic                  clk_i,
  input  logic                  arst_n_i,
  iob_rom_rr_arbiter_if.slave   bus,
  output logic                  prio_dbg_o
);

  // --------------------------------------------------------------------------
  // Priority pointer: names the port that wins when both request together.
  // --------------------------------------------------------------------------
  typedef enum logic {
    PRIO_R1 = 1'b0,
    PRIO_R2 = 1'b1
  } prio_e;

  prio_e prio_q;
  prio_e prio_d;

  logic              gnt1;
  logic              gnt2;
  logic              xfer;
  logic [ADDR_W-1:0] rom_addr_d;

  // Stage 1: which port (if any) has a ROM read in flight.
  logic s1_vld_q;
  logic s1_sel_q;   // 0 = port 1, 1 = port 2

  // Stage 2: returned data and the rvalid pulses.
  logic [DATA_W-1:0] r1_rdata_q;
  logic [DATA_W-1:0] r2_rdata_q;
  logic              r1_rvalid_q;
  logic              r2_rvalid_q;

  // --------------------------------------------------------------------------
  // Grant. A lone requester always wins; a tie goes to the pointer.
  // The grant is forced low while reset is asserted so that nothing
  // is accepted (and the ROM is not enabled) during reset, even though the
  // combinational path would otherwise follow the valid inputs.
  // Because the grant depends only on the valid inputs and the pointer,
  // ready never depends on ready.
  // --------------------------------------------------------------------------
  always_comb begin
    gnt1 = 1'b0;
    gnt2 = 1'b0;
    if (arst_n_i) begin
      if (bus.r1_valid_i && bus.r2_valid_i) begin
        gnt1 = (prio_q == PRIO_R1);
        gnt2 = (prio_q == PRIO_R2);
      end else begin
        gnt1 = bus.r1_valid_i;
        gnt2 = bus.r2_valid_i;
      end
    end
  end

  assign xfer = gnt1 | gnt2;

  // ROM address is driven to zero when idle rather than left floating on
  // the last request, which keeps the ROM port quiet between reads.
  always_comb begin
    rom_addr_d = '0;
    if (gnt1) begin
      rom_addr_d = bus.r1_addr_i;
    end else if (gnt2) begin
      rom_addr_d = bus.r2_addr_i;
    end
  end

  // --------------------------------------------------------------------------
  // Pointer next state. After a transfer the priority passes to the port
  // that was not just served; with no transfer it holds. Under continuous
  // requests from both ports this gives a strict 1,2,1,2 alternation, and a
  // port that was served alone several times in a row still yields to the
  // other port the moment it shows up.
  // --------------------------------------------------------------------------
  always_comb begin
    prio_d = prio_q;
    if (gnt1) begin
      prio_d = PRIO_R2;
    end else if (gnt2) begin
      prio_d = PRIO_R1;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      prio_q <= PRIO_R1;
    end else begin
      prio_q <= prio_d;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 1: remember who issued the read that the ROM is servicing.
  // Clearing s1_vld_q on reset drops any read in flight, so no rvalid pulse
  // appears for it after reset is released.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      s1_vld_q <= 1'b0;
      s1_sel_q <= 1'b0;
    end else begin
      s1_vld_q <= xfer;
      s1_sel_q <= gnt2;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: steer ROM data to the recorded port. Each rdata register loads
  // only when its own read completes, so it holds the last value otherwise.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r1_rdata_q  <= '0;
      r2_rdata_q  <= '0;
      r1_rvalid_q <= 1'b0;
      r2_rvalid_q <= 1'b0;
    end else begin
      r1_rvalid_q <= s1_vld_q && !s1_sel_q;
      r2_rvalid_q <= s1_vld_q &&  s1_sel_q;
      if (s1_vld_q && !s1_sel_q) begin
        r1_rdata_q <= bus.rom_data_i;
      end
      if (s1_vld_q && s1_sel_q) begin
        r2_rdata_q <= bus.rom_data_i;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.r1_ready_o  = gnt1;
  assign bus.r2_ready_o  = gnt2;
  assign bus.rom_en_o    = xfer;
  assign bus.rom_addr_o  = rom_addr_d;
  assign bus.r1_rdata_o  = r1_rdata_q;
  assign bus.r2_rdata_o  = r2_rdata_q;
  assign bus.r1_rvalid_o = r1_rvalid_q;
  assign bus.r2_rvalid_o = r2_rvalid_q;
  assign prio_dbg_o      = prio_q;

endmodule

// File: tb/tb_iob_rom_rr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_iob_rom_rr_arbiter
//
// Bench for iob_rom_rr_arbiter. A behavioural ROM holds mem[i] = i + 32.
// A negedge monitor keeps a reference model of the arbiter (a priority
// port number and a queue of expected responses tagged with the cycle they
// are due) and compares every cycle; the scenario tasks add directed checks.
// ----------------------------------------------------------------------------
module tb_iob_rom_rr_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;
  localparam int AMAX   = (1 << ADDR_W) - 1;

  // --------------------------------------------------------------------------
  // Clock / reset
  // --------------------------------------------------------------------------
  logic clk    = 1'b0;
  logic arst_n = 1'b0;
  logic prio_dbg;
  int   cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  iob_rom_rr_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();

  iob_rom_rr_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk_i      (clk),
    .arst_n_i   (arst_n),
    .bus        (bus),
    .prio_dbg_o (prio_dbg)
  );

  function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
    return DATA_W'(a) + DATA_W'(32);
  endfunction

  // Synchronous ROM: data appears the cycle after the enable.
  always @(posedge clk) begin
    if (bus.rom_en_o) bus.rom_data_i <= rom_word(bus.rom_addr_o);
  end

  // --------------------------------------------------------------------------
  // Scoreboard / reference model
  // --------------------------------------------------------------------------
  int total = 0;
  int bad   = 0;

  logic [DATA_W-1:0] exp_q[$];
  int                port_q[$];
  int                due_q[$];
  logic [DATA_W-1:0] last1 = '0;
  logic [DATA_W-1:0] last2 = '0;
  int                m_ptr = 1;
  bit                m_g1, m_g2, m_ev1, m_ev2;
  logic [ADDR_W-1:0] m_addr;

  always @(negedge clk) begin
    if (!arst_n) begin
      exp_q.delete();
      port_q.delete();
      due_q.delete();
      last1 = '0;
      last2 = '0;
      m_ptr = 1;
    end else begin
      // responses due this cycle
      m_ev1 = 1'b0;
      m_ev2 = 1'b0;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        if (port_q[0] == 1) begin m_ev1 = 1'b1; last1 = exp_q[0]; end
        else                begin m_ev2 = 1'b1; last2 = exp_q[0]; end
        void'(exp_q.pop_front());
        void'(port_q.pop_front());
        void'(due_q.pop_front());
      end
      total++;
      if (bus.r1_rvalid_o !== m_ev1) begin
        bad++; $display("FAIL mon_rvalid1 cyc=%0d got=%0b exp=%0b", cyc, bus.r1_rvalid_o, m_ev1);
      end
      total++;
      if (bus.r2_rvalid_o !== m_ev2) begin
        bad++; $display("FAIL mon_rvalid2 cyc=%0d got=%0b exp=%0b", cyc, bus.r2_rvalid_o, m_ev2);
      end
      total++;
      if (bus.r1_rdata_o !== last1) begin
        bad++; $display("FAIL mon_rdata1 cyc=%0d got=%0h exp=%0h", cyc, bus.r1_rdata_o, last1);
      end
      total++;
      if (bus.r2_rdata_o !== last2) begin
        bad++; $display("FAIL mon_rdata2 cyc=%0d got=%0h exp=%0h", cyc, bus.r2_rdata_o, last2);
      end

      // arbitration: lone requester wins, tie goes to the priority port
      m_g1 = 1'b0;
      m_g2 = 1'b0;
      if (bus.r1_valid_i && bus.r2_valid_i) begin
        if (m_ptr == 1) m_g1 = 1'b1; else m_g2 = 1'b1;
      end else begin
        m_g1 = bus.r1_valid_i;
        m_g2 = bus.r2_valid_i;
      end
      m_addr = m_g1 ? bus.r1_addr_i : (m_g2 ? bus.r2_addr_i : '0);

      total++;
      if (bus.r1_ready_o !== m_g1) begin
        bad++; $display("FAIL mon_ready1 cyc=%0d got=%0b exp=%0b", cyc, bus.r1_ready_o, m_g1);
      end
      total++;
      if (bus.r2_ready_o !== m_g2) begin
        bad++; $display("FAIL mon_ready2 cyc=%0d got=%0b exp=%0b", cyc, bus.r2_ready_o, m_g2);
      end
      total++;
      if (bus.rom_en_o !== (m_g1 | m_g2)) begin
        bad++; $display("FAIL mon_rom_en cyc=%0d got=%0b exp=%0b", cyc, bus.rom_en_o, m_g1 | m_g2);
      end
      total++;
      if (bus.rom_addr_o !== m_addr) begin
        bad++; $display("FAIL mon_rom_addr cyc=%0d got=%0d exp=%0d", cyc, bus.rom_addr_o, m_addr);
      end

      if (m_g1 || m_g2) begin
        exp_q.push_back(rom_word(m_addr));
        port_q.push_back(m_g1 ? 1 : 2);
        due_q.push_back(cyc + 2);
        m_ptr = m_g1 ? 2 : 1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Driver tasks
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v1, input logic [ADDR_W-1:0] a1,
                       input bit v2, input logic [ADDR_W-1:0] a2);
    bus.r1_valid_i = v1;
    bus.r1_addr_i  = a1;
    bus.r2_valid_i = v2;
    bus.r2_addr_i  = a2;
  endtask

  task automatic do_reset();
    drive(1'b0, '0, 1'b0, '0);
    arst_n = 1'b0;
    tick();
    tick();
    arst_n = 1'b1;
  endtask

  function automatic logic [ADDR_W-1:0] pick_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return '0;
    if (r == 1) return ADDR_W'(AMAX);
    return ADDR_W'($urandom_range(0, AMAX));
  endfunction

  // --------------------------------------------------------------------------
  // Scenarios
  // --------------------------------------------------------------------------
  task automatic test_reset();
    drive(1'b1, pick_addr(), 1'b1, pick_addr());
    arst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({bus.r1_ready_o, bus.r2_ready_o, bus.rom_en_o, bus.r1_rvalid_o, bus.r2_rvalid_o} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=00000",
        {bus.r1_ready_o, bus.r2_ready_o, bus.rom_en_o, bus.r1_rvalid_o, bus.r2_rvalid_o});
    end
    total++;
    if (bus.rom_addr_o !== '0) begin
      bad++; $display("FAIL reset_rom_addr got=%0d exp=0", bus.rom_addr_o);
    end
    total++;
    if (bus.r1_rdata_o !== '0 || bus.r2_rdata_o !== '0) begin
      bad++; $display("FAIL reset_rdata got=%0h/%0h exp=0/0", bus.r1_rdata_o, bus.r2_rdata_o);
    end
    total++;
    if (prio_dbg !== 1'b0) begin
      bad++; $display("FAIL reset_prio got=%0b exp=0", prio_dbg);
    end
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    @(negedge clk);
    total++;
    if (bus.r1_ready_o !== 1'b1 || bus.r2_ready_o !== 1'b0) begin
      bad++; $display("FAIL reset_first_grant got=%0b%0b exp=10", bus.r1_ready_o, bus.r2_ready_o);
    end
    tick();
    drive(1'b0, '0, 1'b0, '0);
    repeat (3) tick();
  endtask

  task automatic test_port1_alone();
    do_reset();
    drive(1'b1, 10'd5, 1'b0, '0);
    @(negedge clk);
    total++;
    if (bus.r1_ready_o !== 1'b1 || bus.rom_en_o !== 1'b1 || bus.rom_addr_o !== 10'd5) begin
      bad++; $display("FAIL p1_accept got=rdy%0b en%0b addr%0d exp=rdy1 en1 addr5",
        bus.r1_ready_o, bus.rom_en_o, bus.rom_addr_o);
    end
    tick();
    drive(1'b0, '0, 1'b0, '0);
    @(negedge clk);
    total++;
    if (bus.r1_rvalid_o !== 1'b0) begin
      bad++; $display("FAIL p1_early_rvalid got=%0b exp=0", bus.r1_rvalid_o);
    end
    tick();
    @(negedge clk);
    total++;
    if (bus.r1_rvalid_o !== 1'b1 || bus.r1_rdata_o !== 32'd37 || bus.r2_rvalid_o !== 1'b0) begin
      bad++; $display("FAIL p1_response got=rv%0b data%0d rv2%0b exp=rv1 data37 rv2_0",
        bus.r1_rvalid_o, bus.r1_rdata_o, bus.r2_rvalid_o);
    end
    tick();
    @(negedge clk);
    total++;
    if (bus.r1_rvalid_o !== 1'b0 || bus.r1_rdata_o !== 32'd37) begin
      bad++; $display("FAIL p1_pulse_end got=rv%0b data%0d exp=rv0 data37", bus.r1_rvalid_o, bus.r1_rdata_o);
    end
    tick();
  endtask

  task automatic test_alternate();
    logic [DATA_W-1:0] got1[$];
    logic [DATA_W-1:0] got2[$];
    int grants[$];
    int i1, i2, first_idle;
    do_reset();
    i1 = 0; i2 = 0; first_idle = -1;
    for (int c = 0; c < 12; c++) begin
      drive(i1 < 4, (i1 < 4) ? ADDR_W'(i1) : '0, i2 < 4, (i2 < 4) ? ADDR_W'(100 + i2) : '0);
      @(negedge clk);
      if (!bus.rom_en_o && first_idle < 0) first_idle = c;
      if (bus.r1_ready_o) begin grants.push_back(1); i1++; end
      if (bus.r2_ready_o) begin grants.push_back(2); i2++; end
      if (bus.r1_rvalid_o) got1.push_back(bus.r1_rdata_o);
      if (bus.r2_rvalid_o) got2.push_back(bus.r2_rdata_o);
      tick();
    end
    total++;
    if (first_idle != 8) begin
      bad++; $display("FAIL alt_rom_en_run got=%0d exp=8", first_idle);
    end
    total++;
    if (grants.size() != 8) begin
      bad++; $display("FAIL alt_grant_count got=%0d exp=8", grants.size());
    end
    for (int k = 0; k < grants.size() && k < 8; k++) begin
      total++;
      if (grants[k] != ((k % 2 == 0) ? 1 : 2)) begin
        bad++; $display("FAIL alt_grant_order k=%0d got=%0d exp=%0d", k, grants[k], (k % 2 == 0) ? 1 : 2);
      end
    end
    total++;
    if (got1.size() != 4 || got2.size() != 4) begin
      bad++; $display("FAIL alt_resp_count got=%0d/%0d exp=4/4", got1.size(), got2.size());
    end
    for (int k = 0; k < 4 && k < got1.size(); k++) begin
      total++;
      if (got1[k] !== DATA_W'(32 + k)) begin
        bad++; $display("FAIL alt_data1 k=%0d got=%0d exp=%0d", k, got1[k], 32 + k);
      end
    end
    for (int k = 0; k < 4 && k < got2.size(); k++) begin
      total++;
      if (got2[k] !== DATA_W'(132 + k)) begin
        bad++; $display("FAIL alt_data2 k=%0d got=%0d exp=%0d", k, got2[k], 132 + k);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] a1;
    do_reset();
    a1 = pick_addr();
    for (int c = 0; c < 8; c++) begin
      // Port 2 reads the top address four times, then port 1 joins;
      // port 2 keeps its fifth request raised until it is accepted.
      drive(c == 4, a1, c <= 5, ADDR_W'(AMAX));
      @(negedge clk);
      if (c < 4 || c == 5) begin
        total++;
        if (bus.r2_ready_o !== 1'b1 || bus.rom_addr_o !== ADDR_W'(AMAX)) begin
          bad++; $display("FAIL b2b_p2_accept c=%0d got=rdy%0b addr%0d exp=rdy1 addr%0d",
            c, bus.r2_ready_o, bus.rom_addr_o, AMAX);
        end
      end
      if (c == 4) begin
        total++;
        if (bus.r1_ready_o !== 1'b1 || bus.r2_ready_o !== 1'b0) begin
          bad++; $display("FAIL b2b_p1_next got=%0b%0b exp=10", bus.r1_ready_o, bus.r2_ready_o);
        end
      end
      if (c >= 2 && c <= 5) begin
        total++;
        if (bus.r2_rvalid_o !== 1'b1 || bus.r2_rdata_o !== 32'd1055) begin
          bad++; $display("FAIL b2b_p2_resp c=%0d got=rv%0b data%0d exp=rv1 data1055",
            c, bus.r2_rvalid_o, bus.r2_rdata_o);
        end
      end
      if (c == 6) begin
        total++;
        if (bus.r1_rvalid_o !== 1'b1 || bus.r2_rvalid_o !== 1'b0 || bus.r1_rdata_o !== rom_word(a1)) begin
          bad++; $display("FAIL b2b_p1_resp got=rv%0b rv2%0b data%0d exp=rv1 rv2_0 data%0d",
            bus.r1_rvalid_o, bus.r2_rvalid_o, bus.r1_rdata_o, rom_word(a1));
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_inflight();
    do_reset();
    // completed read first so rdata1 is non-zero before the reset
    drive(1'b1, 10'd7, 1'b0, '0);
    tick();
    drive(1'b0, '0, 1'b0, '0);
    repeat (3) tick();
    drive(1'b1, 10'd10, 1'b0, '0);
    @(negedge clk);
    total++;
    if (bus.r1_ready_o !== 1'b1) begin
      bad++; $display("FAIL inflight_accept got=%0b exp=1", bus.r1_ready_o);
    end
    tick();
    drive(1'b0, '0, 1'b0, '0);
    arst_n = 1'b0;
    tick();
    arst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++;
      if (bus.r1_rvalid_o !== 1'b0 || bus.r1_rdata_o !== '0) begin
        bad++; $display("FAIL inflight_discard c=%0d got=rv%0b data%0d exp=rv0 data0",
          c, bus.r1_rvalid_o, bus.r1_rdata_o);
      end
      tick();
    end
    total++;
    if (prio_dbg !== 1'b0) begin
      bad++; $display("FAIL inflight_prio got=%0b exp=0", prio_dbg);
    end
    drive(1'b1, pick_addr(), 1'b1, pick_addr());
    @(negedge clk);
    total++;
    if (bus.r1_ready_o !== 1'b1 || bus.r2_ready_o !== 1'b0) begin
      bad++; $display("FAIL inflight_grant got=%0b%0b exp=10", bus.r1_ready_o, bus.r2_ready_o);
    end
    tick();
    drive(1'b0, '0, 1'b0, '0);
    repeat (3) tick();
  endtask

  task automatic test_idle();
    logic [ADDR_W-1:0] a2;
    do_reset();
    a2 = pick_addr();
    drive(1'b0, '0, 1'b1, a2);
    tick();
    drive(1'b0, '0, 1'b0, '0);
    repeat (3) tick();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total++;
      if (bus.rom_en_o !== 1'b0 || bus.rom_addr_o !== '0 || bus.r1_rvalid_o !== 1'b0 || bus.r2_rvalid_o !== 1'b0) begin
        bad++; $display("FAIL idle_ctrl c=%0d got=en%0b addr%0d rv%0b%0b exp=en0 addr0 rv00",
          c, bus.rom_en_o, bus.rom_addr_o, bus.r1_rvalid_o, bus.r2_rvalid_o);
      end
      total++;
      if (bus.r2_rdata_o !== rom_word(a2) || bus.r1_rdata_o !== '0) begin
        bad++; $display("FAIL idle_hold c=%0d got=%0d/%0d exp=0/%0d",
          c, bus.r1_rdata_o, bus.r2_rdata_o, rom_word(a2));
      end
      tick();
    end
  endtask

  task automatic test_random();
    bit p1, p2;
    logic [ADDR_W-1:0] a1, a2;
    do_reset();
    p1 = 1'b0; p2 = 1'b0; a1 = '0; a2 = '0;
    for (int c = 0; c < 600; c++) begin
      if (!p1 && $urandom_range(0, 99) < 60) begin p1 = 1'b1; a1 = pick_addr(); end
      if (!p2 && $urandom_range(0, 99) < 60) begin p2 = 1'b1; a2 = pick_addr(); end
      drive(p1, a1, p2, a2);
      if (c == 300) arst_n = 1'b0;
      if (c == 301) arst_n = 1'b1;
      @(negedge clk);
      if (bus.r1_ready_o) p1 = 1'b0;
      if (bus.r2_ready_o) p2 = 1'b0;
      tick();
    end
    drive(1'b0, '0, 1'b0, '0);
    repeat (4) tick();
  endtask

  // --------------------------------------------------------------------------
  // Sequence and report
  // --------------------------------------------------------------------------
  initial begin
    bus.rom_data_i = '0;
    drive(1'b0, '0, 1'b0, '0);
    test_reset();
    test_port1_alone();
    test_alternate();
    test_back_to_back();
    test_reset_inflight();
    test_idle();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
